pc_fetch_unit: RTL

Holds the architectural program counter and consumes the NextPC value produced by the next-PC logic. Issues one instruction-memory read per PC over a valid/ready request channel and captures the returned word. Presents the instruction and its PC (the CurrentPC fed back to next-PC logic) to decode over a valid/ready handshake. Sits between next-PC logic and instruction memory, at the front of the LEGv8 datapath.

---
 rtl/lemv8_fetch_pkg.sv | 18 +
 rtl/pc_fetch_unit_if.sv | 28 ++
 rtl/pc_fetch_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/lemv8_fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch front end.
package lemv8_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits & INSTR_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bus bundle between the fetch unit, next-PC logic, instruction memory and decode.
interface pc_fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  NextPC;
  logic               IMemReqValid;
  logic               IMemReqReady;
  logic [ADDR_W-1:0]  IMemAddr;
  logic               IMemRspValid;
  logic [INSTR_W-1:0] IMemRspData;
  logic               InstrValid;
  logic               InstrReady;
  logic [INSTR_W-1:0] Instr;
  logic [ADDR_W-1:0]  CurrentPC;
  logic               FetchFault;
  logic [31:0]        FetchCount;

  modport master (
    input  NextPC, IMemReqReady, IMemRspValid, IMemRspData, InstrReady,
    output IMemReqValid, IMemAddr, InstrValid, Instr, CurrentPC, FetchFault, FetchCount
  );

  modport slave (
    output NextPC, IMemReqReady, IMemRspValid, IMemRspData, InstrReady,
    input  IMemReqValid, IMemAddr, InstrValid, Instr, CurrentPC, FetchFault, FetchCount
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register plus a single-outstanding fetch FSM: request, wait for the word,
// hold it for decode, then load NextPC (or latch a fault on misalignment).
module pc_fetch_unit
  import lemv8_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
  input  logic             CLK,
  input  logic             Reset_L,
  pc_fetch_unit_if.master  bus
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               fault_q, fault_d;
  logic [31:0]        count_q, count_d;
  logic               req_valid;
  logic               instr_valid;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    fault_d     = fault_q;
    count_d     = count_q;
    req_valid   = 1'b0;
    instr_valid = 1'b0;

    unique case (state_q)
      FETCH_REQ: begin
        req_valid = 1'b1;
        if (bus.IMemReqReady) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (bus.IMemRspValid) begin
          instr_d = bus.IMemRspData;
          state_d = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        instr_valid = 1'b1;
        if (bus.InstrReady) begin
          count_d = count_q + 32'd1;
          // A misaligned target leaves the PC alone so CurrentPC still names the last good fetch.
          if (is_word_aligned(bus.NextPC[1:0])) begin
            pc_d    = bus.NextPC;
            state_d = FETCH_REQ;
          end else begin
            fault_d = 1'b1;
            state_d = FETCH_FAULT;
          end
        end
      end
      FETCH_FAULT: begin
        state_d = FETCH_FAULT;
      end
      default: begin
        state_d = FETCH_FAULT;
      end
    endcase
  end

  // Valids are gated by the reset pin so they drop the instant reset asserts.
  assign bus.IMemReqValid = req_valid & Reset_L;
  assign bus.InstrValid   = instr_valid & Reset_L;
  assign bus.IMemAddr     = pc_q;
  assign bus.CurrentPC    = pc_q;
  assign bus.Instr        = instr_q;
  assign bus.FetchFault   = fault_q;
  assign bus.FetchCount   = count_q;

endmodule
